// File: rtl/seq_add_sub.sv
// Multi-cycle two's-complement adder/subtractor: WIDTH-bit operands processed CHUNK bits per
// clock, LSB chunk first, with a registered carry chaining the slices.
module seq_add_sub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, part_q, sum_q;
  logic             carry_q, done_q, cout_q, ovf_q, zero_q;
  logic [IdxW-1:0]  idx_q;

  logic [31:0]      base;
  logic [CHUNK-1:0] slice_a, slice_b;
  logic [CHUNK:0]   slice_res;
  logic [WIDTH-1:0] full_d;
  logic             last, cin_msb;

  always_comb begin
    base      = 32'(idx_q) * CHUNK;
    slice_a   = a_q[base +: CHUNK];
    slice_b   = b_q[base +: CHUNK];
    slice_res = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry_q};
    full_d    = part_q;
    full_d[base +: CHUNK] = slice_res[CHUNK-1:0];
    last      = (idx_q == IdxW'(NCHUNK - 1));
    // Carry into the MSB recovered from the MSB sum bit and its (inverted-for-sub) operands.
    cin_msb   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ full_d[WIDTH-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StRun;
            a_q     <= a_i;
            b_q     <= b_i ^ {WIDTH{op_i}};
            carry_q <= op_i;
            idx_q   <= '0;
            part_q  <= '0;
          end
        end
        StRun: begin
          part_q  <= full_d;
          carry_q <= slice_res[CHUNK];
          idx_q   <= idx_q + IdxW'(1);
          if (last) begin
            state_q <= StIdle;
            sum_q   <= full_d;
            cout_q  <= slice_res[CHUNK];
            ovf_q   <= cin_msb ^ slice_res[CHUNK];
            zero_q  <= (full_d == '0);
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;
  assign zero_o = zero_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// Bench for seq_add_sub: 16/4 instance driven by a vector table, handshake and reset
// sequences and random ops; 8/8 instance for the single-cycle configuration.
module tb_seq_add_sub;

  logic        clk, rst;
  logic        start16, op16, busy16, done16, cout16, ovf16, zero16;
  logic [15:0] a16, b16, sum16;
  logic        start8, op8, busy8, done8, cout8, ovf8, zero8;
  logic [7:0]  a8, b8, sum8;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] prev16 = 0;
  logic [31:0] prev8  = 0;

  seq_add_sub #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk_i(clk), .rst_i(rst), .start_i(start16), .op_i(op16), .a_i(a16), .b_i(b16),
    .busy_o(busy16), .done_o(done16), .sum_o(sum16), .cout_o(cout16), .ovf_o(ovf16),
    .zero_o(zero16)
  );

  seq_add_sub #(.WIDTH(8), .CHUNK(8)) u8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .op_i(op8), .a_i(a8), .b_i(b8),
    .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8), .ovf_o(ovf8),
    .zero_o(zero8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Independent reference: widened add of a and the (optionally inverted) b plus op.
  task automatic model(input int w, input logic op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] s, output logic c, output logic v, output logic z);
    logic [32:0] m, bb, full;
    m    = (33'd1 << w) - 33'd1;
    bb   = ({1'b0, b} ^ (op ? m : 33'd0)) & m;
    full = ({1'b0, a} & m) + bb + {32'd0, op};
    s    = full[31:0] & m[31:0];
    c    = full[w];
    v    = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    z    = (s == 0);
  endtask

  // Launch one op on the 16/4 instance and wait for done; returns edges from acceptance.
  task automatic run16(input logic op, input logic [15:0] a, input logic [15:0] b,
                       output int lat);
    start16 = 1'b1; op16 = op; a16 = a; b16 = b;
    tick();
    start16 = 1'b0; op16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 0;
    while (!done16 && lat < 20) begin
      chk("busy16 in run", 32'(busy16), 32'd1);
      chk("sum16 holds", 32'(sum16), prev16);
      tick();
      lat++;
    end
    if (!done16) chk("done16 timeout", 32'(done16), 32'd1);
    chk("busy16 at done", 32'(busy16), 32'd0);
  endtask

  task automatic run8(input logic op, input logic [7:0] a, input logic [7:0] b, output int lat);
    start8 = 1'b1; op8 = op; a8 = a; b8 = b;
    tick();
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    while (!done8 && lat < 20) begin
      chk("sum8 holds", 32'(sum8), prev8);
      tick();
      lat++;
    end
    if (!done8) chk("done8 timeout", 32'(done8), 32'd1);
  endtask

  typedef struct {
    logic        op;
    logic [15:0] a, b, s;
    logic        c, v, z;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, ndone;
    logic [31:0] es;
    logic ec, ev, ez, rop;
    logic [15:0] ra, rb;

    vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; start16 = 1'b0; op16 = 1'b0; a16 = '0; b16 = '0;
    start8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset busy16", 32'(busy16), 0);
    chk("reset done16", 32'(done16), 0);
    chk("reset flags16", {sum16, cout16, ovf16, zero16}, 0);
    chk("reset busy8/done8", {busy8, done8}, 0);
    chk("reset flags8", {sum8, cout8, ovf8, zero8}, 0);

    // Back-to-back: each run starts in the previous op's done cycle.
    for (int i = 0; i < 8; i++) begin
      run16(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d latency", i), lat, 4);
      chk($sformatf("vec%0d sum", i), 32'(sum16), 32'(vecs[i].s));
      chk($sformatf("vec%0d cout", i), 32'(cout16), 32'(vecs[i].c));
      chk($sformatf("vec%0d ovf", i), 32'(ovf16), 32'(vecs[i].v));
      chk($sformatf("vec%0d zero", i), 32'(zero16), 32'(vecs[i].z));
      prev16 = 32'(vecs[i].s);
    end
    tick();
    chk("done16 one-cycle", 32'(done16), 0);

    // start during RUN is ignored.
    start16 = 1'b1; op16 = 1'b0; a16 = 16'h0001; b16 = 16'h0001;
    tick();
    start16 = 1'b0;
    tick(); tick();
    start16 = 1'b1; op16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222;
    tick();
    start16 = 1'b0;
    chk("ignored start no done", 32'(done16), 0);
    tick();
    chk("ignored start done", 32'(done16), 1);
    chk("ignored start sum", 32'(sum16), 32'h0002);
    prev16 = 32'h0002;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done16) ndone++;
    end
    chk("ignored start extra done", ndone, 0);

    // Reset in the third RUN cycle aborts the op.
    run16(1'b1, 16'h8000, 16'h0001, lat);
    chk("pre-reset sum", 32'(sum16), 32'h7FFF);
    prev16 = 32'h7FFF;
    start16 = 1'b1; op16 = 1'b0; a16 = 16'h1234; b16 = 16'h0FFF;
    tick();
    start16 = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy/done", {busy16, done16}, 0);
    chk("abort outputs", {sum16, cout16, ovf16, zero16}, 0);
    prev16 = 0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done16) ndone++;
    end
    chk("abort no done", ndone, 0);

    // Reset and start on the same edge: reset wins.
    rst = 1'b1; start16 = 1'b1;
    tick();
    rst = 1'b0; start16 = 1'b0;
    chk("rst beats start", 32'(busy16), 0);

    run16(1'b0, 16'h1234, 16'h0FFF, lat);
    chk("post-reset latency", lat, 4);
    chk("post-reset sum", 32'(sum16), 32'h2233);
    prev16 = 32'h2233;

    for (int i = 0; i < 1000; i++) begin
      rop = 1'($urandom); ra = 16'($urandom); rb = 16'($urandom);
      if (i % 50 == 0) rb = (rop ? ra : 16'(-ra));
      model(16, rop, 32'(ra), 32'(rb), es, ec, ev, ez);
      run16(rop, ra, rb, lat);
      chk("rand16 latency", lat, 4);
      chk("rand16 result", {sum16, cout16, ovf16, zero16}, {es[15:0], ec, ev, ez});
      prev16 = es;
    end

    // Single-chunk configuration.
    run8(1'b1, 8'h80, 8'h01, lat);
    chk("w8 latency", lat, 1);
    chk("w8 sum", 32'(sum8), 32'h7F);
    chk("w8 ovf", 32'(ovf8), 1);
    chk("w8 cout", 32'(cout8), 1);
    prev8 = 32'h7F;
    for (int i = 0; i < 200; i++) begin
      rop = 1'($urandom); ra = 16'($urandom); rb = 16'($urandom);
      model(8, rop, 32'(ra[7:0]), 32'(rb[7:0]), es, ec, ev, ez);
      run8(rop, ra[7:0], rb[7:0], lat);
      chk("rand8 latency", lat, 1);
      chk("rand8 result", {sum8, cout8, ovf8, zero8}, {es[7:0], ec, ev, ez});
      prev8 = es;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
